// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: captures A/B, computes A-B LSB-first one bit per clock,
// and returns the difference and final borrow over a valid/ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  assign d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // New bit enters at the MSB so the LSB-first result is in place after WIDTH steps
  assign res_d   = (res_q >> 1) | (WIDTH'(d_bit_d) << (WIDTH - 1));

  // Control FSM, operand shifters and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q      <= res_d;
            borrow_q    <= br_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit and a 1-bit instance, directed boundary
// cases plus random operands, checked against plain modular arithmetic.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] iv, ir, ov, ordy, bo;
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic [7:0] dv0;
  logic       dv1;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int         unit;
    logic [7:0] d;
    logic       br;
    int         acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .diff(dv0), .borrow(bo[0])
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1][0:0]), .b(bv[1][0:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .diff(dv1), .borrow(bo[1])
  );

  function automatic int wid(input int u);
    return (u == 0) ? 8 : 1;
  endfunction

  function automatic logic [7:0] dval(input int u);
    return (u == 0) ? dv0 : {7'd0, dv1};
  endfunction

  // Pops an expectation whenever a DUT presents a result; checks latency and value
  task automatic monitor_loop();
    logic [1:0] prev_ov = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        if (ov[u]) begin
          if (sb.size() == 0 || sb[0].unit != u) begin
            tests++; fails++;
            $display("FAIL unexpected_result unit%0d: diff=%0d borrow=%0d with no pending operation", u, dval(u), bo[u]);
          end else begin
            if (!prev_ov[u]) begin
              tests++;
              if (cyc - sb[0].acc != wid(u)) begin
                fails++;
                $display("FAIL latency unit%0d: got %0d cycles, expected %0d", u, cyc - sb[0].acc, wid(u));
              end
            end
            tests++;
            if (dval(u) !== sb[0].d || bo[u] !== sb[0].br) begin
              fails++;
              $display("FAIL result unit%0d: diff=%0d borrow=%0d, expected diff=%0d borrow=%0d",
                       u, dval(u), bo[u], sb[0].d, sb[0].br);
            end
            if (ordy[u]) void'(sb.pop_front());
          end
        end
        prev_ov[u] = ov[u];
      end
    end
  endtask

  task automatic check_idle(input int u, input string name);
    tests++;
    if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || dval(u) !== 8'd0 || bo[u] !== 1'b0) begin
      fails++;
      $display("FAIL %s unit%0d: in_ready=%0d out_valid=%0d diff=%0d borrow=%0d, expected 1/0/0/0",
               name, u, ir[u], ov[u], dval(u), bo[u]);
    end
  endtask

  // One full transaction: accept, optional in_valid noise while busy, hold backpressure, drain
  task automatic op(input int u, input logic [7:0] aa_in, input logic [7:0] bb_in,
                    input int hold, input bit tog);
    logic [7:0] m, aa, bb;
    exp_t e;
    int held;
    bit done_s;
    m  = (u == 0) ? 8'hFF : 8'h01;
    aa = aa_in & m;
    bb = bb_in & m;
    @(negedge clk);
    for (int k = 0; k < 20 && !ir[u]; k++) @(negedge clk);
    tests++;
    if (!ir[u]) begin
      fails++;
      $display("FAIL ready_timeout unit%0d: in_ready=%0d, expected 1", u, ir[u]);
      return;
    end
    av[u] = aa; bv[u] = bb; iv[u] = 1'b1;
    ordy[u] = 1'($urandom_range(0, 1));
    e.unit = u; e.d = (aa - bb) & m; e.br = (aa < bb); e.acc = cyc + 1;
    sb.push_back(e);
    held = 0; done_s = 0;
    for (int k = 0; k < wid(u) + hold + 20 && !done_s; k++) begin
      @(negedge clk);
      tests++;
      if (ir[u] !== 1'b0) begin
        fails++;
        $display("FAIL busy_ready unit%0d: in_ready=%0d, expected 0", u, ir[u]);
      end
      if (tog) begin
        iv[u] = 1'($urandom_range(0, 1)); av[u] = 8'($urandom); bv[u] = 8'($urandom);
      end else begin
        iv[u] = 1'b0;
      end
      if (ov[u]) begin
        if (held >= hold) begin
          ordy[u] = 1'b1; iv[u] = 1'b0; done_s = 1;
        end else begin
          ordy[u] = 1'b0; held++;
        end
      end else begin
        ordy[u] = 1'($urandom_range(0, 1));
      end
    end
    if (!done_s) begin
      tests++; fails++;
      $display("FAIL done_timeout unit%0d: out_valid=%0d, expected 1", u, ov[u]);
    end
    @(negedge clk);
    iv[u] = 1'b0; ordy[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv = 2'b00; ordy = 2'b00;
    av[0] = 8'd0; av[1] = 8'd0; bv[0] = 8'd0; bv[1] = 8'd0;
    fork monitor_loop(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle(0, "reset_state");
    check_idle(1, "reset_state");

    op(0, 8'd200, 8'd55, 0, 1'b0);
    op(0, 8'd5, 8'd9, 0, 1'b0);
    op(0, 8'd0, 8'd255, 0, 1'b0);
    op(0, 8'hAA, 8'hAA, 0, 1'b0);
    op(0, 8'd173, 8'd0, 0, 1'b0);
    op(0, 8'd100, 8'd1, 5, 1'b0);
    op(0, 8'd123, 8'd45, 3, 1'b1);
    op(0, 8'd17, 8'd250, 2, 1'b1);

    // Reset and in_valid together: reset must win, nothing captured
    @(negedge clk);
    rst = 1'b1; iv[0] = 1'b1; av[0] = 8'd60; bv[0] = 8'd6;
    @(negedge clk);
    rst = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "rst_vs_in_valid");

    // Reset while bit 4 is being processed abandons the operation
    av[0] = 8'd50; bv[0] = 8'd20; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "reset_mid_run");
    op(0, 8'd7, 8'd3, 0, 1'b0);

    op(1, 8'd0, 8'd0, 0, 1'b0);
    op(1, 8'd1, 8'd0, 0, 1'b0);
    op(1, 8'd0, 8'd1, 0, 1'b0);
    op(1, 8'd1, 8'd1, 0, 1'b0);
    op(1, 8'd1, 8'd0, 2, 1'b1);

    for (int n = 0; n < 40; n++)
      op(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 10; n++)
      op(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
